// File: rtl/mux4_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_pkg
// Description : Shared types and constants for the 4-to-1 mux arbiter:
//               Gray-coded select values, arbiter state enum, index->select.
// Revision    : 1.0  initial release
// ============================================================================
package mux4_pkg;

    // Gray-coded mux select per source
    localparam logic [1:0] SEL_S0 = 2'b00;
    localparam logic [1:0] SEL_S1 = 2'b01;
    localparam logic [1:0] SEL_S2 = 2'b11;
    localparam logic [1:0] SEL_S3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Map a source index to its Gray-coded select value
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] s;
        case (idx)
            2'd0:    s = SEL_S0;
            2'd1:    s = SEL_S1;
            2'd2:    s = SEL_S2;
            default: s = SEL_S3;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority picker. Scans requests
//               starting at the pointer and wrapping mod 4; reports the
//               first set bit as the winner.
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_winner
);

    logic [1:0] w_idx;

    // Scan from the farthest candidate down to ptr so the closest one wins
    always_comb begin
        o_valid  = 1'b0;
        o_winner = i_ptr;
        w_idx    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter / select sequencer for a shared 4-to-1
//               mux. One owner at a time, Gray-coded select held for the
//               whole ownership, bounded hold time, one drain cycle between
//               owners. All outputs are registered.
// Revision    : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter
    import mux4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    state_t           r_state, w_state;
    logic [3:0]       r_grant, w_grant;
    logic [1:0]       r_sel,   w_sel;
    logic             r_busy,  w_busy;
    logic             r_timeout, w_timeout;
    logic [1:0]       r_ptr,   w_ptr;
    logic [1:0]       r_owner, w_owner;
    logic [CNT_W-1:0] r_cnt,   w_cnt;

    logic             w_valid;
    logic [1:0]       w_winner;
    logic             w_owner_req;
    logic             w_expire;

    rr_pick4 u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_owner_req = req[r_owner];
    assign w_expire    = (r_cnt == c_hold_last);

    // Next-state and next-output decode
    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_sel     = r_sel;
        w_busy    = r_busy;
        w_timeout = r_timeout;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_cnt     = r_cnt;
        case (r_state)
            IDLE: begin
                w_grant   = 4'b0000;
                w_busy    = 1'b0;
                w_timeout = 1'b0;
                if (w_valid) begin
                    w_state = OWN;
                    w_grant = 4'b0001 << w_winner;
                    w_sel   = idx_to_sel(w_winner);
                    w_busy  = 1'b1;
                    w_owner = w_winner;
                    w_cnt   = '0;
                end
            end
            OWN: begin
                // done beats a dropped request, which beats expiry; only a
                // pure expiry raises the timeout pulse
                if (done || !w_owner_req || w_expire) begin
                    w_state   = DRAIN;
                    w_grant   = 4'b0000;
                    w_busy    = 1'b1;
                    w_timeout = !done && w_owner_req;
                    w_ptr     = r_owner + 2'd1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DRAIN: begin
                w_state   = IDLE;
                w_busy    = 1'b0;
                w_timeout = 1'b0;
            end
            default: begin
                w_state   = IDLE;
                w_grant   = 4'b0000;
                w_busy    = 1'b0;
                w_timeout = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= 4'b0000;
            r_sel     <= SEL_S0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_sel     <= w_sel;
            r_busy    <= w_busy;
            r_timeout <= w_timeout;
            r_ptr     <= w_ptr;
            r_owner   <= w_owner;
            r_cnt     <= w_cnt;
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and select sequencer for the shared 4-to-1 signal mux. Four requesters compete for the mux. The block grants one owner at a time and drives the mux select in the team's Gray-coded select encoding. It holds the select stable for the whole ownership, enforces a maximum hold time, and inserts a drain cycle between owners.

Parameters:
MAX_HOLD, 16, max cycles one owner may hold the mux before forced release (legal range 2..255)
CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state at the clock edge where it is high
req  input  4  request per source; bit i = source i wants the mux
done  input  1  current owner finished; sampled only in OWN
sel  output  2  mux select, Gray-coded: src0=00, src1=01, src2=11, src3=10
grant  output  4  one-hot grant to current owner, all zero otherwise
busy  output  1  high in OWN and DRAIN
timeout  output  1  one-cycle pulse when an ownership ends by MAX_HOLD expiry

Behaviour:
- All outputs are registered. Reset values: grant=0000, sel=00, busy=0, timeout=0, state=IDLE, priority pointer ptr=0, hold count=0.
- States: IDLE, OWN, DRAIN.
- IDLE, req==0: stay in IDLE; sel keeps its last value; grant=0.
- IDLE, req!=0: the winner is the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: grant=onehot(winner), sel=code(winner), busy=1, count=0, go to OWN.
  - Latency: req seen at edge N gives grant visible after edge N (one cycle).
- OWN: grant and sel are stable and count increments each cycle. Release is evaluated in this priority order:
  - (a) done=1: release, timeout stays 0.
  - (b) req[owner]=0: release, timeout stays 0.
  - (c) count==MAX_HOLD-1: release with timeout=1 for exactly one cycle (the DRAIN cycle).
  - done and expiry in the same cycle counts as (a), so no timeout pulse.
- On release (next edge): grant=0000, sel held at the owner's code, busy=1, ptr=(owner+1) mod 4, go to DRAIN.
- DRAIN: lasts exactly 1 cycle; req is ignored. Next edge: busy=0, timeout=0, go to IDLE.
- Minimum gap between two grants is 2 cycles (DRAIN + IDLE). grant is never non-zero for two different sources in consecutive cycles.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,...; no source waits more than 3 ownerships.
- Requests that appear or drop for non-owners during OWN or DRAIN have no effect until IDLE.
- Reset mid-ownership: on the reset edge, outputs return to their reset values immediately and ptr returns to 0.
- Outside reset, grant is always one-hot or zero.

Decomposition:
- Package mux4_pkg holds:
  - select codes SEL_S0=2'b00, SEL_S1=2'b01, SEL_S2=2'b11, SEL_S3=2'b10;
  - state enum IDLE/OWN/DRAIN;
  - function idx_to_sel.
- Sub-module rr_pick4: combinational rotating-priority picker. Inputs are req[3:0] and ptr[1:0]; outputs are a valid flag and winner[1:0]. It is instantiated once.

Test Plan:
1. reset high 2 cycles, then req=0100 -> after 1 edge grant=0100, sel=11, busy=1; done pulse -> next edge grant=0000, sel=11; one edge later busy=0.
2. req=1111 held, done pulsed 2 cycles after each grant -> grant sequence 0001,0010,0100,1000,0001 with sel 00,01,11,10,00 and a 2-cycle zero-grant gap between each.
3. MAX_HOLD=4, req=0010 held, no done -> grant=0010 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0000; re-grant to source 1 after the DRAIN and IDLE cycles.
4. Owner 3 drops req[3] while req=0001 is pending -> release on the next edge, ptr=0, then grant=0001 two cycles later, timeout=0.
5. done and count==MAX_HOLD-1 in the same cycle -> release with timeout=0.
6. reset asserted while in OWN with grant=1000 -> next edge grant=0000, sel=00, busy=0; then req=1001 -> grant=0001, confirming ptr was reset to 0.
